// File: rtl/div_unit_pkg.sv
// Shared constants, operation encodings and FSM states for the iterative divider.
package div_unit_pkg;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   // Iteration counter runs 0..XLEN-1.
   localparam int CNT_W  = $clog2(XLEN);

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
// The quotient register starts out holding the dividend and shifts its bits
// into the remainder while quotient bits shift in from the right.
module div_iter_core
   import div_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            last_step,
   output logic [XLEN-1:0] quotient_next,
   output logic [XLEN-1:0] remainder_next
);

   logic [XLEN:0]      rem_q;
   logic [XLEN-1:0]    quo_q;
   logic [XLEN-1:0]    dsr_q;
   logic [CNT_W-1:0]   count;
   logic [XLEN:0]      rem_shift;
   logic [XLEN:0]      diff;
   logic [XLEN:0]      rem_step;
   logic [XLEN-1:0]    quo_step;

   // One restoring step: shift in next dividend bit, trial-subtract, keep if no borrow.
   always_comb begin
      rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, quo_q[XLEN-1]};
      diff      = rem_shift - {1'b0, dsr_q};
      if (diff[XLEN]) begin
         rem_step = rem_shift;
         quo_step = {quo_q[XLEN-2:0], 1'b0};
      end else begin
         rem_step = diff;
         quo_step = {quo_q[XLEN-2:0], 1'b1};
      end
   end

   // Step results are exported combinationally so the final step can be captured directly.
   assign quotient_next  = quo_step;
   assign remainder_next = rem_step[XLEN-1:0];
   assign last_step      = (count == CNT_W'(XLEN - 1));

   // Datapath registers: load operands, then advance one step per enabled cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         count <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dsr_q <= divisor;
         count <= '0;
      end else if (step) begin
         rem_q <= rem_step;
         quo_q <= quo_step;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/div_unit.sv
// RISC-V DIV/DIVU/REM/REMU unit: FSM, sign handling, fast paths and register-file write-back.
// Handshake: start is sampled only in IDLE; busy is high in RUN and DONE; done is a
// one-cycle pulse with wb_data/wb_addr valid; flush aborts any operation at the next edge.
module div_unit
   import div_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic [1:0]        op,
   input  logic [XLEN-1:0]   dividend,
   input  logic [XLEN-1:0]   divisor,
   input  logic [ADDR_W-1:0] rd_in,
   output logic              busy,
   output logic              done,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [XLEN-1:0]   wb_data
);

   state_t            state, state_next;
   logic              is_rem_q, q_neg_q, r_neg_q;
   logic [ADDR_W-1:0] rd_q;

   logic              op_signed, a_neg, b_neg, div_zero, overflow, fast_path;
   logic [XLEN-1:0]   a_mag, b_mag, fast_result, run_result, q_raw, r_raw;
   logic              load, step, last_step, from_idle;
   logic [ADDR_W-1:0] addr_src;

   div_iter_core u_core (
      .clk            (clk),
      .reset          (reset),
      .load           (load),
      .step           (step),
      .dividend       (a_mag),
      .divisor        (b_mag),
      .last_step      (last_step),
      .quotient_next  (q_raw),
      .remainder_next (r_raw)
   );

   // Operand decode: magnitudes, sign flags and the two single-cycle special cases.
   always_comb begin
      op_signed = (op == OP_DIV) || (op == OP_REM);
      a_neg     = op_signed && dividend[XLEN-1];
      b_neg     = op_signed && divisor[XLEN-1];
      a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
      b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
      div_zero  = (divisor == '0);
      overflow  = op_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
      fast_path = div_zero || overflow;
      if (div_zero) begin
         fast_result = op[1] ? dividend : '1;
      end else begin
         fast_result = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   // Final sign fix-up: quotient negated on differing signs, remainder follows the dividend.
   always_comb begin
      if (is_rem_q) begin
         run_result = r_neg_q ? (~r_raw + 1'b1) : r_raw;
      end else begin
         run_result = q_neg_q ? (~q_raw + 1'b1) : q_raw;
      end
   end

   // Next-state and datapath controls; flush overrides everything.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = fast_path ? DONE : RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
         load       = 1'b0;
         step       = 1'b0;
      end
   end

   // Fast-path completions take address and data straight from the IDLE-cycle inputs.
   assign from_idle = (state == IDLE);
   assign addr_src  = from_idle ? rd_in : rd_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Operation attributes captured when a request is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         rd_q     <= '0;
      end else if (load) begin
         is_rem_q <= op[1];
         q_neg_q  <= a_neg ^ b_neg;
         r_neg_q  <= a_neg;
         rd_q     <= rd_in;
      end
   end

   // Registered handshake and write-back outputs; wb_addr/wb_data change only on entry to DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
         wb_en <= 1'b0;
         if (state_next == DONE) begin
            wb_en   <= (addr_src != '0);
            wb_addr <= addr_src;
            wb_data <= from_idle ? fast_result : run_result;
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, flush/reset/ignored-start scenarios
// and randomized operations against an arithmetic reference model.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int EW = 1 + ADDR_W + XLEN;  // {wb_en, wb_addr, wb_data}

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              flush = 1'b0;
   logic [1:0]        op = 2'b00;
   logic [XLEN-1:0]   dividend = '0;
   logic [XLEN-1:0]   divisor = '0;
   logic [ADDR_W-1:0] rd_in = '0;
   logic              busy, done, wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [XLEN-1:0]   wb_data;

   logic [EW-1:0] exp_q[$];
   int            cyc_q[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .flush    (flush),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data)
   );

   // ---------------- clock / reset block ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] ref_result(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      if (b == 0) return (o == OP_REM || o == OP_REMU) ? a : 32'hFFFF_FFFF;
      case (o)
         OP_DIV:  return 32'(sa / sb);
         OP_REM:  return 32'(sa % sb);
         OP_DIVU: return 32'(ua / ub);
         default: return 32'(ua % ub);
      endcase
   endfunction

   function automatic bit is_fast(input logic [1:0] o, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b);
      return (b == 0) ||
             ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; issues one accepted operation and waits for the unit to go idle.
   task automatic do_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [ADDR_W-1:0] rd, input bit noise);
      int k;
      exp_q.push_back({rd != 0, rd, ref_result(o, a, b)});
      cyc_q.push_back(cyc + 1 + (is_fast(o, a, b) ? 0 : 32));
      op = o; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); dividend = $urandom; divisor = $urandom; rd_in = 5'($urandom);
      k = 0;
      while (busy && k < 60) begin
         @(negedge clk);
         k++;
         start = noise && (k == 4 || k == 19);
      end
      start = 1'b0;
      check("op_timeout_busy", 64'(busy), 64'd0);
   endtask

   function automatic logic [XLEN-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      int            ec;
      if (!reset) begin
         checks++;
         if (wb_en !== (done && wb_addr != 0)) begin
            errors++;
            $display("FAIL wb_en_rule: wb_en=%b done=%b wb_addr=%0d", wb_en, done, wb_addr);
         end
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: cycle %0d wb_data=%h wb_addr=%0d", cyc, wb_data, wb_addr);
            end else begin
               e  = exp_q.pop_front();
               ec = cyc_q.pop_front();
               if ({wb_en, wb_addr, wb_data} !== e) begin
                  errors++;
                  $display("FAIL result: got en=%b addr=%0d data=%h expected en=%b addr=%0d data=%h",
                           wb_en, wb_addr, wb_data, e[EW-1], e[EW-2:XLEN], e[XLEN-1:0]);
               end
               checks++;
               if (cyc != ec) begin
                  errors++;
                  $display("FAIL latency: done at cycle %0d expected cycle %0d", cyc, ec);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_wb_en", 64'(wb_en), 64'd0);
      check("reset_wb_addr", 64'(wb_addr), 64'd0);
      check("reset_wb_data", 64'(wb_data), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases.
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0);
      do_op(OP_REMU, 32'd100, 32'd7, 5'd5, 1'b0);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd7, 1'b0);
      do_op(OP_DIV, 32'h1234, 32'd0, 5'd8, 1'b0);
      do_op(OP_REMU, 32'h1234, 32'd0, 5'd9, 1'b0);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
      do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);

      // Start pulses during RUN are ignored: one done only.
      do_op(OP_DIVU, 32'd1000, 32'd9, 5'd13, 1'b1);

      // Flush in RUN at cycle 10: no done, idle at cycle 11, new start accepted there.
      op = OP_DIVU; dividend = 32'd5000; divisor = 32'd3; rd_in = 5'd14; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      do_op(OP_REMU, 32'd5000, 32'd3, 5'd15, 1'b0);

      // Flush together with start in IDLE: request not accepted.
      op = OP_DIVU; dividend = 32'd50; divisor = 32'd0; rd_in = 5'd16;
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("flush_start_done", 64'(done), 64'd0);

      // Async reset mid-RUN after a known non-zero result.
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0);
      op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; rd_in = 5'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_busy", 64'(busy), 64'd0);
      check("async_done", 64'(done), 64'd0);
      check("async_wb_en", 64'(wb_en), 64'd0);
      check("async_wb_data", 64'(wb_data), 64'd0);
      check("async_wb_addr", 64'(wb_addr), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_op(OP_DIVU, 32'd9, 32'd3, 5'd0, 1'b0);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         do_op(2'($urandom_range(0, 3)), pick(), pick(),
               ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), 1'b0);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
